// File: rtl/serial_injection_arbiter_if.sv
// serial_injection_arbiter_if: request, serial data and busy bundle between local sources, arbiter and router port
interface serial_injection_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CW = 16
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] src_data;
    logic [NUM_REQ-1:0] src_busy;
    logic out_data;
    logic out_busy;
    logic [NUM_REQ-1:0] grant;
    logic [CW-1:0] pkt_count;
    modport master (
        input req, src_data, out_busy,
        output src_busy, out_data, grant, pkt_count
    );
    modport slave (
        output req, src_data, out_busy,
        input src_busy, out_data, grant, pkt_count
    );
endinterface

// File: rtl/serial_injection_arbiter.sv
// serial_injection_arbiter: round-robin packet arbiter sharing one serial router input among local sources
module serial_injection_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int FLIT_BITS = 8,
    parameter int PKT_FLITS = 4,
    parameter int TIMEOUT = 16,
    parameter int CW = 16
) (
    input logic clk,
    input logic reset,
    serial_injection_arbiter_if.master bus
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int BW = FLIT_BITS > 1 ? $clog2(FLIT_BITS) : 1;
    localparam int FW = $clog2(PKT_FLITS + 1);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_START, SHIFT} state_t;

    state_t state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [FW-1:0] flit_cnt_q, flit_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic out_data_q, out_data_d;
    logic [CW-1:0] pkt_count_q, pkt_count_d;
    logic [PW-1:0] g_idx, win_idx, cand, next_ptr;
    logic win_found, g_data;

    // binary index of the one-hot grant
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant_q[i]) g_idx = PW'(i);
    end

    assign g_data = bus.src_data[g_idx];
    assign next_ptr = (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;

    // first pending request at or after the round-robin pointer
    always_comb begin
        win_found = 1'b0;
        win_idx = '0;
        cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx = cand;
            end
        end
    end

    // grant/flit sequencing; backpressure only gates start bits, never an in-flight flit
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d = ptr_q;
        bit_cnt_d = bit_cnt_q;
        flit_cnt_d = flit_cnt_q;
        to_cnt_d = to_cnt_q;
        pkt_count_d = pkt_count_q;
        out_data_d = (state_q != IDLE) && g_data;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    state_d = WAIT_START;
                    to_cnt_d = '0;
                    flit_cnt_d = '0;
                end
            end
            WAIT_START: begin
                if (g_data && !bus.out_busy) begin
                    state_d = SHIFT;
                    bit_cnt_d = '0;
                end else if (!bus.out_busy) begin
                    if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        grant_d = '0;
                        ptr_d = next_ptr;
                        state_d = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bit_cnt_q == BW'(FLIT_BITS - 1)) begin
                    flit_cnt_d = flit_cnt_q + 1'b1;
                    if (flit_cnt_d == FW'(PKT_FLITS)) begin
                        grant_d = '0;
                        ptr_d = next_ptr;
                        pkt_count_d = pkt_count_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_START;
                        to_cnt_d = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q <= '0;
            bit_cnt_q <= '0;
            flit_cnt_q <= '0;
            to_cnt_q <= '0;
            out_data_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q <= ptr_d;
            bit_cnt_q <= bit_cnt_d;
            flit_cnt_q <= flit_cnt_d;
            to_cnt_q <= to_cnt_d;
            out_data_q <= out_data_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.out_data = out_data_q;
    assign bus.pkt_count = pkt_count_q;
    assign bus.src_busy = ~(grant_q & {NUM_REQ{!bus.out_busy && state_q != SHIFT}});
endmodule

// File: tb/tb_serial_injection_arbiter.sv
// tb_serial_injection_arbiter: directed self-checking bench for the serial injection arbiter
module tb_serial_injection_arbiter;
    localparam int NUM_REQ = 4;
    localparam int FLIT_BITS = 8;
    localparam int PKT_FLITS = 4;
    localparam int TIMEOUT = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int fails = 0;

    serial_injection_arbiter_if #(.NUM_REQ(NUM_REQ), .CW(CW)) bus ();

    serial_injection_arbiter #(
        .NUM_REQ(NUM_REQ),
        .FLIT_BITS(FLIT_BITS),
        .PKT_FLITS(PKT_FLITS),
        .TIMEOUT(TIMEOUT),
        .CW(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input int idx, input logic [7:0] payload, input string tag);
        logic [8:0] bits;
        bits = {1'b1, payload};
        for (int b = 8; b >= 0; b--) begin
            bus.src_data = ~(NUM_REQ'(1) << idx);
            bus.src_data[idx] = bits[b];
            tick();
            checks++;
            if (bus.out_data !== bits[b]) begin
                fails++;
                $display("FAIL %s bit %0d: out_data=%b expected %b", tag, 8 - b, bus.out_data, bits[b]);
            end
        end
        bus.src_data = '0;
    endtask

    task automatic send_packet(input int idx, input logic [7:0] base, input string tag);
        for (int f = 0; f < PKT_FLITS; f++) send_flit(idx, base + 8'(f), tag);
    endtask

    task automatic test_reset();
        bus.req = '0;
        bus.src_data = '0;
        bus.out_busy = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
        checks++;
        if (bus.out_data !== 1'b0) begin fails++; $display("FAIL reset_out_data: got %b expected 0", bus.out_data); end
        checks++;
        if (bus.pkt_count !== 16'd0) begin fails++; $display("FAIL reset_pkt_count: got %0d expected 0", bus.pkt_count); end
        checks++;
        if (bus.src_busy !== 4'b1111) begin fails++; $display("FAIL reset_src_busy: got %b expected 1111", bus.src_busy); end
        reset = 1'b0;
    endtask

    task automatic test_single_requester();
        bus.req = 4'b0001;
        tick();
        checks++;
        if (bus.grant !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b expected 0001", bus.grant); end
        checks++;
        if (bus.src_busy !== 4'b1110) begin fails++; $display("FAIL single_src_busy: got %b expected 1110", bus.src_busy); end
        for (int f = 0; f < PKT_FLITS; f++) begin
            send_flit(0, 8'hA5, "single");
            if (f < PKT_FLITS - 1) begin
                checks++;
                if (bus.grant !== 4'b0001) begin fails++; $display("FAIL single_hold flit %0d: grant=%b expected 0001", f, bus.grant); end
            end
        end
        bus.req = '0;
        checks++;
        if (bus.grant !== 4'b0000) begin fails++; $display("FAIL single_release: grant=%b expected 0000", bus.grant); end
        checks++;
        if (bus.pkt_count !== 16'd1) begin fails++; $display("FAIL single_pkt_count: got %0d expected 1", bus.pkt_count); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_grant [4];
        int exp_idx [4];
        exp_grant = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        exp_idx = '{0, 1, 3, 0};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 4'b1011;
        for (int p = 0; p < 4; p++) begin
            tick();
            checks++;
            if (bus.grant !== exp_grant[p]) begin fails++; $display("FAIL rr_grant %0d: got %b expected %b", p, bus.grant, exp_grant[p]); end
            send_packet(exp_idx[p], 8'h10 * 8'(p), "rr");
            if (p == 3) bus.req = '0;
            checks++;
            if (bus.grant !== 4'b0000) begin fails++; $display("FAIL rr_idle_gap %0d: grant=%b expected 0000", p, bus.grant); end
        end
        checks++;
        if (bus.pkt_count !== 16'd4) begin fails++; $display("FAIL rr_pkt_count: got %0d expected 4", bus.pkt_count); end
    endtask

    task automatic test_backpressure();
        bus.req = 4'b0001;
        tick();
        checks++;
        if (bus.grant !== 4'b0001) begin fails++; $display("FAIL bp_grant: got %b expected 0001", bus.grant); end
        for (int c = 0; c < 10; c++) tick();
        bus.out_busy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({bus.grant, bus.src_busy} !== {4'b0001, 4'b1111}) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: grant=%b src_busy=%b expected 0001/1111", c, bus.grant, bus.src_busy);
            end
        end
        bus.out_busy = 1'b0;
        #1;
        checks++;
        if (bus.src_busy !== 4'b1110) begin fails++; $display("FAIL bp_release_busy: got %b expected 1110", bus.src_busy); end
        send_flit(0, 8'h96, "bp");
        for (int f = 1; f < PKT_FLITS; f++) send_flit(0, 8'h69, "bp");
        bus.req = '0;
        checks++;
        if (bus.grant !== 4'b0000) begin fails++; $display("FAIL bp_release: grant=%b expected 0000", bus.grant); end
        checks++;
        if (bus.pkt_count !== 16'd5) begin fails++; $display("FAIL bp_pkt_count: got %0d expected 5", bus.pkt_count); end
    endtask

    task automatic test_mid_flit_busy();
        logic [8:0] bits;
        bits = {1'b1, 8'hC3};
        bus.req = 4'b0001;
        tick();
        checks++;
        if (bus.grant !== 4'b0001) begin fails++; $display("FAIL mid_grant: got %b expected 0001", bus.grant); end
        for (int j = 0; j < 9; j++) begin
            bus.src_data[0] = bits[8 - j];
            bus.out_busy = (j >= 4);
            tick();
            checks++;
            if (bus.out_data !== bits[8 - j]) begin fails++; $display("FAIL mid_bit %0d: out_data=%b expected %b", j, bus.out_data, bits[8 - j]); end
        end
        bus.src_data[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.src_busy !== 4'b1111) begin fails++; $display("FAIL mid_gated %0d: src_busy=%b expected 1111", c, bus.src_busy); end
        end
        bus.out_busy = 1'b0;
        bus.src_data = '0;
        for (int f = 1; f < PKT_FLITS; f++) begin
            send_flit(0, 8'h5A, "mid");
            if (f < PKT_FLITS - 1) begin
                checks++;
                if (bus.grant !== 4'b0001) begin fails++; $display("FAIL mid_hold flit %0d: grant=%b expected 0001", f, bus.grant); end
            end
        end
        bus.req = '0;
        checks++;
        if (bus.grant !== 4'b0000) begin fails++; $display("FAIL mid_release: grant=%b expected 0000", bus.grant); end
        checks++;
        if (bus.pkt_count !== 16'd6) begin fails++; $display("FAIL mid_pkt_count: got %0d expected 6", bus.pkt_count); end
    endtask

    task automatic test_timeout();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 4'b0010;
        tick();
        checks++;
        if (bus.grant !== 4'b0010) begin fails++; $display("FAIL to_first_grant: got %b expected 0010", bus.grant); end
        send_packet(1, 8'h21, "to");
        bus.req = 4'b0110;
        tick();
        checks++;
        if (bus.grant !== 4'b0100) begin fails++; $display("FAIL to_grant2: got %b expected 0100", bus.grant); end
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            checks++;
            if (c < TIMEOUT && bus.grant !== 4'b0100) begin
                fails++;
                $display("FAIL to_hold cycle %0d: grant=%b expected 0100", c, bus.grant);
            end else if (c == TIMEOUT && bus.grant !== 4'b0000) begin
                fails++;
                $display("FAIL to_expire: grant=%b expected 0000", bus.grant);
            end
        end
        tick();
        checks++;
        if (bus.grant !== 4'b0010) begin fails++; $display("FAIL to_next_grant: got %b expected 0010", bus.grant); end
        checks++;
        if (bus.pkt_count !== 16'd1) begin fails++; $display("FAIL to_pkt_count: got %0d expected 1", bus.pkt_count); end
    endtask

    task automatic test_reset_mid_packet();
        send_flit(1, 8'h5A, "rst_mid");
        for (int j = 0; j < 5; j++) begin
            bus.src_data[1] = 1'b1;
            tick();
            checks++;
            if (bus.out_data !== 1'b1) begin fails++; $display("FAIL rst_mid_bit %0d: out_data=%b expected 1", j, bus.out_data); end
        end
        bus.src_data[1] = 1'b1;
        bus.req = '0;
        reset = 1'b1;
        tick();
        checks++;
        if (bus.grant !== 4'b0000) begin fails++; $display("FAIL rst_mid_grant: got %b expected 0000", bus.grant); end
        checks++;
        if (bus.out_data !== 1'b0) begin fails++; $display("FAIL rst_mid_out_data: got %b expected 0", bus.out_data); end
        checks++;
        if (bus.pkt_count !== 16'd0) begin fails++; $display("FAIL rst_mid_pkt_count: got %0d expected 0", bus.pkt_count); end
        checks++;
        if (bus.src_busy !== 4'b1111) begin fails++; $display("FAIL rst_mid_src_busy: got %b expected 1111", bus.src_busy); end
        reset = 1'b0;
        bus.src_data = '0;
        bus.req = 4'b0001;
        tick();
        checks++;
        if (bus.grant !== 4'b0001) begin fails++; $display("FAIL rst_mid_regrant: got %b expected 0001", bus.grant); end
        send_packet(0, 8'hE0, "rst_mid_pkt");
        bus.req = '0;
        checks++;
        if (bus.grant !== 4'b0000) begin fails++; $display("FAIL rst_mid_release: grant=%b expected 0000", bus.grant); end
        checks++;
        if (bus.pkt_count !== 16'd1) begin fails++; $display("FAIL rst_mid_final_count: got %0d expected 1", bus.pkt_count); end
    endtask

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_backpressure();
        test_mid_flit_busy();
        test_timeout();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
